// File: rtl/dense_layer.sv
// Serial dense layer: buffers one frame of activations, then computes each
// neuron as bias + dot(w, x) from external synchronous-read RAMs and emits saturated results.
//
// state | meaning
// IDLE  | waiting for start; counters cleared
// LOAD  | capturing IN_COUNT activations into the input buffer
// BIAS  | presenting bias address j and first weight address
// ACC   | multiply-accumulate over IN_COUNT weights of neuron j
// OUT   | registered result visible with valid; advance or finish
module dense_layer #(
  parameter int IN_COUNT  = 10,
  parameter int OUT_COUNT = 3,
  parameter int DATA_SIZE = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic signed [DATA_SIZE-1:0]               dataIn,
  input  logic signed [DATA_SIZE-1:0]               weightData,
  input  logic signed [DATA_SIZE-1:0]               biasData,
  output logic                                      busy,
  output logic                                      valid,
  output logic signed [DATA_SIZE-1:0]               dataOut,
  output logic [$clog2(IN_COUNT*OUT_COUNT)-1:0]     weightAdr,
  output logic [$clog2(OUT_COUNT)-1:0]              biasAdr
);

  localparam int WA = $clog2(IN_COUNT*OUT_COUNT);
  localparam int BA = $clog2(OUT_COUNT);
  localparam int CW = $clog2(IN_COUNT);
  localparam int PW = 2*DATA_SIZE;
  localparam int AW = PW + CW + 1;

  localparam logic [CW-1:0] LAST_IN  = CW'(IN_COUNT-1);
  localparam logic [BA-1:0] LAST_OUT = BA'(OUT_COUNT-1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BIAS,
    S_ACC,
    S_OUT
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0]               cnt;
  logic                        last_in;
  logic                        last_out;
  logic signed [DATA_SIZE-1:0] x_buf [0:IN_COUNT-1];
  logic signed [DATA_SIZE-1:0] x_cur;
  logic signed [PW-1:0]        prod;
  logic signed [AW-1:0]        prod_ext;
  logic signed [AW-1:0]        bias_ext;
  logic signed [AW-1:0]        acc;
  logic signed [AW-1:0]        acc_next;
  logic signed [DATA_SIZE-1:0] sat_val;

  assign last_in  = (cnt == LAST_IN);
  assign last_out = (biasAdr == LAST_OUT);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_LOAD;
      S_LOAD: if (last_in) state_next = S_BIAS;
      S_BIAS: state_next = S_ACC;
      S_ACC:  if (last_in) state_next = S_OUT;
      S_OUT:  state_next = last_out ? S_IDLE : S_BIAS;
      default: state_next = S_IDLE;
    endcase
  end

  // cnt indexes the input buffer both while loading and while accumulating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (state)
        S_LOAD, S_ACC: cnt <= last_in ? '0 : cnt + CW'(1);
        default:       cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD) x_buf[cnt] <= dataIn;
  end

  always_comb begin
    x_cur    = x_buf[cnt];
    prod     = weightData * x_cur;
    prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    bias_ext = {{(AW-DATA_SIZE){biasData[DATA_SIZE-1]}}, biasData};
    acc_next = (cnt == '0) ? bias_ext + prod_ext : acc + prod_ext;
    if (acc_next > SAT_MAX)      sat_val = {1'b0, {(DATA_SIZE-1){1'b1}}};
    else if (acc_next < SAT_MIN) sat_val = {1'b1, {(DATA_SIZE-1){1'b0}}};
    else                         sat_val = acc_next[DATA_SIZE-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 acc <= '0;
    else if (state == S_ACC) acc <= acc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      dataOut <= '0;
    end else begin
      valid <= (state == S_ACC) && last_in;
      if ((state == S_ACC) && last_in) dataOut <= sat_val;
    end
  end

  // The address left after the last ACC cycle is already the next neuron's base
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weightAdr <= '0;
    end else begin
      case (state)
        S_BIAS:  weightAdr <= weightAdr + WA'(1);
        S_ACC:   if (!last_in) weightAdr <= weightAdr + WA'(1);
        S_OUT:   if (last_out) weightAdr <= '0;
        default: weightAdr <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      biasAdr <= '0;
    end else begin
      case (state)
        S_OUT:         biasAdr <= last_out ? '0 : biasAdr + BA'(1);
        S_IDLE, S_LOAD: biasAdr <= '0;
        default:       biasAdr <= biasAdr;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer.sv
// Directed bench for dense_layer: RAM models, frame driver with cycle-exact
// checks of valid timing, addresses, busy, and saturated results.
module tb_dense_layer;
  localparam int IN   = 10;
  localparam int OUTN = 3;
  localparam int DS   = 8;
  localparam int WA   = $clog2(IN*OUTN);
  localparam int BA   = $clog2(OUTN);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic signed [DS-1:0] dataIn;
  logic signed [DS-1:0] weightData;
  logic signed [DS-1:0] biasData;
  logic                 busy;
  logic                 valid;
  logic signed [DS-1:0] dataOut;
  logic [WA-1:0]        weightAdr;
  logic [BA-1:0]        biasAdr;

  logic signed [DS-1:0] wmem [0:IN*OUTN-1];
  logic signed [DS-1:0] bmem [0:OUTN-1];
  logic signed [DS-1:0] xv   [0:IN-1];

  int n_chk  = 0;
  int n_pass = 0;
  int got   [0:7];
  int got_e [0:7];
  int nval;

  dense_layer #(.IN_COUNT(IN), .OUT_COUNT(OUTN), .DATA_SIZE(DS)) dut (
    .clk(clk), .rst(rst), .start(start), .dataIn(dataIn),
    .weightData(weightData), .biasData(biasData), .busy(busy), .valid(valid),
    .dataOut(dataOut), .weightAdr(weightAdr), .biasAdr(biasAdr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    weightData <= (int'(weightAdr) < IN*OUTN) ? wmem[weightAdr] : '0;
    biasData   <= (int'(biasAdr) < OUTN) ? bmem[biasAdr] : '0;
  end

  task automatic check(input string tag, input int got_v, input int exp_v);
    n_chk++;
    if (got_v == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
  endtask

  function automatic int sat(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int ref_out(input int j);
    int s;
    s = int'(bmem[j]);
    for (int i = 0; i < IN; i++) s += int'(wmem[j*IN+i]) * int'(xv[i]);
    return sat(s);
  endfunction

  // Drives one frame; e counts edges after E0 and all sampling is #1 past the edge.
  task automatic run_frame(input string name, input int e0, input int e1, input int e2, input bit poke);
    int ex [0:2];
    int jj, ph;
    ex = '{e0, e1, e2};
    nval = 0;
    for (int k = 0; k < 8; k++) begin got[k] = -9999; got_e[k] = -1; end
    @(negedge clk);
    start = 1'b1;
    dataIn = 8'sh33;
    @(posedge clk);
    #1;
    start = 1'b0;
    dataIn = xv[0];
    check({name, "_busy_e0"}, int'(busy), 1);
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      dataIn = (e < IN) ? xv[e] : 8'shA5;
      if (poke && e == 10) start = 1'b1;
      if (poke && e == 14) start = 1'b0;
      if (valid) begin
        if (nval < 8) begin got[nval] = int'(dataOut); got_e[nval] = e; end
        nval++;
      end
      if (e < IN) check({name, "_wadr_load"}, int'(weightAdr), 0);
      if (e >= IN && e < IN + OUTN*(IN+2)) begin
        jj = (e - IN) / (IN+2);
        ph = (e - IN) % (IN+2);
        if (ph == 0) begin
          check({name, "_wadr_bias"}, int'(weightAdr), jj*IN);
          check({name, "_badr"}, int'(biasAdr), jj);
        end else if (ph < IN) begin
          check({name, "_wadr_acc"}, int'(weightAdr), jj*IN + ph);
        end
      end
      if (e == 45) check({name, "_busy_e45"}, int'(busy), 1);
      if (e == 46) begin
        check({name, "_busy_e46"}, int'(busy), 0);
        check({name, "_wadr_idle"}, int'(weightAdr), 0);
      end
    end
    check({name, "_nvalid"}, nval, 3);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("%s_out%0d", name, j), got[j], ex[j]);
      check($sformatf("%s_edge%0d", name, j), got_e[j], 2*IN + 1 + j*(IN+2));
    end
  endtask

  task automatic fill(input int w, input int b, input bit ramp_x, input int xc);
    for (int k = 0; k < IN*OUTN; k++) wmem[k] = 8'(w);
    for (int k = 0; k < OUTN; k++) bmem[k] = 8'(b);
    for (int k = 0; k < IN; k++) xv[k] = ramp_x ? 8'(k+1) : 8'(xc);
  endtask

  initial begin
    int vcnt;
    rst = 1'b1;
    start = 1'b0;
    dataIn = '0;
    fill(0, 0, 1'b0, 0);
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_dout", int'(dataOut), 0);
    check("rst_wadr", int'(weightAdr), 0);
    check("rst_badr", int'(biasAdr), 0);
    @(negedge clk);
    rst = 1'b0;

    fill(1, 0, 1'b1, 0);
    run_frame("sum", 55, 55, 55, 1'b0);

    // abort in the middle of LOAD
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_dout", int'(dataOut), 0);
    check("abort_wadr", int'(weightAdr), 0);
    check("abort_badr", int'(biasAdr), 0);
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (valid || busy) vcnt++;
    end
    check("abort_quiet", vcnt, 0);

    fill(0, 0, 1'b1, 0);
    for (int j = 0; j < OUTN; j++) wmem[j*IN+j] = 8'sd1;
    bmem[0] = 8'sd5;
    bmem[1] = -8'sd3;
    bmem[2] = 8'sd0;
    run_frame("sel", 6, -1, 3, 1'b0);

    fill(127, 0, 1'b0, 127);
    run_frame("satp", 127, 127, 127, 1'b0);
    fill(-128, 0, 1'b0, 127);
    run_frame("satn", -128, -128, -128, 1'b0);

    fill(1, 0, 1'b1, 0);
    run_frame("hs", 55, 55, 55, 1'b1);

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < IN*OUTN; k++) wmem[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < OUTN; k++) bmem[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < IN; k++) xv[k] = 8'($urandom_range(0, 255));
      run_frame($sformatf("rnd%0d", r), ref_out(0), ref_out(1), ref_out(2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dense_layer.md
# dense_layer

Fully connected (dense) neural-network layer for the MNIST CNN datapath. It accepts a serial stream of `IN_COUNT` signed activations and fetches weights and biases from two external synchronous-read RAMs. It then emits `OUT_COUNT` signed, saturated results serially, one per `valid` pulse. It sits after the flatten stage and drives the classifier/argmax stage.

## Interface
- `IN_COUNT`, default 10: number of input activations per frame (≥2).
- `OUT_COUNT`, default 3: number of output neurons (≥2).
- `DATA_SIZE`, default 8: width of activations, weights, biases and outputs; signed two's complement.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `dataIn`  in  DATA_SIZE  input activation stream.
- `weightData`  in  DATA_SIZE  weight RAM read data, one cycle after `weightAdr`.
- `biasData`  in  DATA_SIZE  bias RAM read data, one cycle after `biasAdr`.
- `busy`  out  1  high whenever the state is not IDLE.
- `valid`  out  1  one-cycle pulse per output neuron.
- `dataOut`  out  DATA_SIZE  result for the current neuron; meaningful only while `valid`=1.
- `weightAdr`  out  clog2(IN_COUNT*OUT_COUNT)  weight address; weight (j,i) is stored at j*IN_COUNT+i, neuron-major.
- `biasAdr`  out  clog2(OUT_COUNT)  bias address; bias j is stored at j.

## Operation
- External RAMs are synchronous-read with a registered output. Data for the address presented in cycle t is available in cycle t+1. The block never writes the RAMs.
- States: IDLE, LOAD, BIAS, ACC, OUT.
- IDLE: `start`=1 at an edge moves to LOAD. The input counter is cleared.
- LOAD: at each of the next IN_COUNT edges, `dataIn` is captured into input buffer x[0..IN_COUNT-1] in order. After the last capture the state moves to BIAS with neuron index j=0.
- BIAS (1 cycle): drive `biasAdr`=j and `weightAdr`=j*IN_COUNT. Then go to ACC with i=0.
- ACC (IN_COUNT cycles, i=0..IN_COUNT-1):
  - Cycle i=0: acc = sext(biasData) + weightData*x[0].
  - Cycle i>0: acc += weightData*x[i].
  - `weightAdr` = j*IN_COUNT+i+1 during each ACC cycle; the value in the last cycle is don't-care.
  - After i=IN_COUNT-1, go to OUT.
- OUT (1 cycle):
  - `valid`=1 and `dataOut` = sat(acc).
  - If j<OUT_COUNT-1: j++ and go to BIAS. Otherwise go to IDLE.
- Arithmetic rules:
  - Signed DATA_SIZE × signed DATA_SIZE product, full 2*DATA_SIZE width.
  - Accumulator width is 2*DATA_SIZE+clog2(IN_COUNT)+1 and never overflows.
  - Bias is sign-extended and added unscaled.
  - sat() clamps to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
- `start` during any non-IDLE state is ignored. `start` held high across the return to IDLE begins a new frame.
- `dataIn` is ignored outside LOAD.

## Timing
- Reset: state IDLE and all counters 0. `busy`=0, `valid`=0, `dataOut`=0, `weightAdr`=0, `biasAdr`=0.
- Reset mid-frame aborts immediately. No further `valid` is produced and the partial frame is discarded.
- Edge numbering: E0 is the edge that samples `start`.
  - x[k] is captured at E(k+1).
  - Neuron j's `valid` is high in the cycle after edge 2*IN_COUNT+1+j*(IN_COUNT+2).
  - `busy` falls after edge IN_COUNT+OUT_COUNT*(IN_COUNT+2).
- Per-neuron cost is IN_COUNT+2 cycles. Frame latency is IN_COUNT+OUT_COUNT*(IN_COUNT+2) cycles; with defaults, 46 cycles.
- Outputs are registered. `valid` pulses are never back-to-back; they are separated by IN_COUNT+1 low cycles.
- `weightAdr` and `biasAdr` hold 0 in IDLE and LOAD.

## Test plan
- Reset check: assert `rst` mid-LOAD -> `busy`=0, `valid`=0, `dataOut`=0, addresses 0 immediately. A following `start` runs a clean frame.
- Sum test (defaults): all weights 1, biases 0, x=1..10 -> three `valid` pulses, each `dataOut`=55. `busy` is low after edge 46.
- Selector test: w[j*10+i]=1 iff i==j, else 0; bias={5,-3,0}; x=1..10 -> `dataOut` = 6, -1, 3 in order.
- Saturation test: all weights 0x7F, x=0x7F, bias 0 -> 0x7F ×3. Then weights 0x80, x=0x7F -> 0x80 ×3.
- Handshake test: pulse `start` again during BIAS/ACC -> ignored. Exactly 3 `valid` pulses, at cycles after edges 21, 33 and 45. Weight addresses follow 0..9, 10..19, 20..29 and biasAdr follows 0, 1, 2.
- Random test: random signed x, weights and biases -> each `dataOut` equals the saturated reference dot product plus bias.
